// File: rtl/mipi_csi2_pkg.sv
// mipi_csi2_pkg: shared CSI-2 data types, header layout, FSM states and ECC parity masks.
// The masks are used by mipi_csi2_ecc when MIPI_CSI2_ECC_CHECK_EN is defined.
package mipi_csi2_pkg;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  localparam int DI_LSB  = 0;
  localparam int WC_LSB  = 8;
  localparam int ECC_LSB = 24;
  typedef enum logic [2:0] {IDLE, PAYLOAD, CRC, SKIP, WAIT_LP} state_t;
  // Row j selects the header bits that feed ECC parity bit j
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
  };
  function automatic logic [5:0] ecc_parity(input logic [23:0] hdr);
    for (int j = 0; j < 6; j++) ecc_parity[j] = ^(hdr & ECC_MASK[j]);
  endfunction
endpackage

// File: rtl/mipi_csi2_packet_handler_if.sv
// mipi_csi2_packet_handler_if: lane-word input and payload/sync/error output bundle.
interface mipi_csi2_packet_handler_if;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic [31:0] payload_o;
  logic        payload_valid_o;
  logic        payload_last_o;
  logic [2:0]  payload_bytes_o;
  logic        frame_start_o;
  logic        frame_end_o;
  logic        line_start_o;
  logic        line_end_o;
  logic        err_trunc_o;
  logic        err_ecc_o;
  modport slave (
    input  data_i, data_valid_i,
    output payload_o, payload_valid_o, payload_last_o, payload_bytes_o,
    output frame_start_o, frame_end_o, line_start_o, line_end_o, err_trunc_o, err_ecc_o
  );
  modport master (
    output data_i, data_valid_i,
    input  payload_o, payload_valid_o, payload_last_o, payload_bytes_o,
    input  frame_start_o, frame_end_o, line_start_o, line_end_o, err_trunc_o, err_ecc_o
  );
endinterface

// File: rtl/mipi_csi2_ecc.sv
// mipi_csi2_ecc: header Hamming check; corrects single-bit errors, flags multi-bit ones.
// Only instantiated when MIPI_CSI2_ECC_CHECK_EN is defined.
module mipi_csi2_ecc
  import mipi_csi2_pkg::*;
(
  input  logic [29:0] i_hdr,
  output logic [23:0] o_hdr,
  output logic        o_err
);
  logic [5:0] w_syn;
  logic [5:0] w_col;
  logic       w_hit;
  assign w_syn = ecc_parity(i_hdr[23:0]) ^ i_hdr[ECC_LSB +: 6];
  // Data-bit columns have odd weight >1, so a one-hot syndrome is a parity-bit error
  always_comb begin
    o_hdr = i_hdr[23:0];
    w_hit = 1'b0;
    w_col = '0;
    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 6; j++) w_col[j] = ECC_MASK[j][i];
      if (w_syn == w_col) begin
        o_hdr[i] = ~i_hdr[i];
        w_hit    = 1'b1;
      end
    end
    o_err = (w_syn != '0) && !$onehot(w_syn) && !w_hit;
  end
endmodule

// File: rtl/mipi_csi2_packet_handler.sv
// mipi_csi2_packet_handler: CSI-2 header parse, payload forward with CRC strip, sync pulses.
// Header ECC checking/correction is enabled by defining MIPI_CSI2_ECC_CHECK_EN.
module mipi_csi2_packet_handler
  import mipi_csi2_pkg::*;
#(
  parameter logic [5:0] DT_SEL = DT_RAW10,
  parameter logic [1:0] VC_SEL = 2'd0,
  parameter int         WC_W   = 16
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  mipi_csi2_packet_handler_if.slave  bus
);
  localparam int REM_W = WC_W + 2;
  logic [23:0]     w_hdr;
  logic            w_ecc_err;
  logic            w_unused_ecc;
  logic [1:0]      w_vc;
  logic [5:0]      w_dt;
  logic [WC_W-1:0] w_wc;
  logic            w_v;
  state_t          r_state;
  logic [REM_W-1:0] r_rem;
  logic [31:0]     r_pay;
  logic            r_pv, r_last, r_fs, r_fe, r_ls, r_le, r_trunc, r_ecc;
  logic [2:0]      r_bytes;
`ifdef MIPI_CSI2_ECC_CHECK_EN
  mipi_csi2_ecc u_ecc (.i_hdr(bus.data_i[29:0]), .o_hdr(w_hdr), .o_err(w_ecc_err));
  assign w_unused_ecc = ^bus.data_i[31:30];
`else
  assign w_hdr        = bus.data_i[23:0];
  assign w_ecc_err    = 1'b0;
  assign w_unused_ecc = ^bus.data_i[31:24];
`endif
  assign w_v  = bus.data_valid_i;
  assign w_vc = w_hdr[DI_LSB+6 +: 2];
  assign w_dt = w_hdr[DI_LSB +: 6];
  assign w_wc = w_hdr[WC_LSB +: WC_W];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_pay   <= '0;
      r_pv    <= 1'b0;
      r_last  <= 1'b0;
      r_bytes <= '0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_ls    <= 1'b0;
      r_le    <= 1'b0;
      r_trunc <= 1'b0;
      r_ecc   <= 1'b0;
    end else begin
      r_pv    <= 1'b0;
      r_last  <= 1'b0;
      r_bytes <= '0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
      r_ls    <= 1'b0;
      r_le    <= 1'b0;
      r_trunc <= 1'b0;
      r_ecc   <= 1'b0;
      case (r_state)
        IDLE: if (w_v) begin
          if (w_ecc_err) begin
            r_ecc   <= 1'b1;
            r_state <= WAIT_LP;
          end else if (w_dt < DT_LONG_MIN) begin
            r_fs    <= w_vc == VC_SEL && w_dt == DT_FS;
            r_fe    <= w_vc == VC_SEL && w_dt == DT_FE;
            r_ls    <= w_vc == VC_SEL && w_dt == DT_LS;
            r_le    <= w_vc == VC_SEL && w_dt == DT_LE;
            r_state <= WAIT_LP;
          end else if (w_vc == VC_SEL && w_dt == DT_SEL && w_wc != '0) begin
            r_rem   <= REM_W'(w_wc);
            r_state <= PAYLOAD;
          end else begin
            r_rem   <= REM_W'(w_wc) + REM_W'(2);
            r_state <= SKIP;
          end
        end
        PAYLOAD: if (!w_v) begin
          r_trunc <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_pv  <= 1'b1;
          r_pay <= bus.data_i;
          if (r_rem > REM_W'(4)) begin
            r_bytes <= 3'd4;
            r_rem   <= r_rem - REM_W'(4);
          end else begin
            r_bytes <= r_rem[2:0];
            r_last  <= 1'b1;
            r_rem   <= '0;
            // Fewer than two CRC bytes fit in this word: the rest arrive in the next one
            r_state <= r_rem <= REM_W'(2) ? WAIT_LP : CRC;
          end
        end
        CRC: begin
          r_trunc <= !w_v;
          r_state <= w_v ? WAIT_LP : IDLE;
        end
        SKIP: if (!w_v) begin
          r_trunc <= 1'b1;
          r_state <= IDLE;
        end else if (r_rem > REM_W'(4)) begin
          r_rem <= r_rem - REM_W'(4);
        end else begin
          r_rem   <= '0;
          r_state <= WAIT_LP;
        end
        WAIT_LP: r_state <= w_v ? WAIT_LP : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.payload_o       = r_pay;
  assign bus.payload_valid_o = r_pv;
  assign bus.payload_last_o  = r_last;
  assign bus.payload_bytes_o = r_bytes;
  assign bus.frame_start_o   = r_fs;
  assign bus.frame_end_o     = r_fe;
  assign bus.line_start_o    = r_ls;
  assign bus.line_end_o      = r_le;
  assign bus.err_trunc_o     = r_trunc;
  assign bus.err_ecc_o       = r_ecc;
endmodule

// File: tb/tb_mipi_csi2_packet_handler.sv
// tb_mipi_csi2_packet_handler: directed bursts with a scoreboard of expected output events.
module tb_mipi_csi2_packet_handler;
  typedef struct packed {
    logic        pv;
    logic [31:0] d;
    logic [2:0]  b;
    logic        l;
    logic        fs, fe, ls, le, tr, ec;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];
  always #5 clk = ~clk;
  mipi_csi2_packet_handler_if bus ();
  mipi_csi2_packet_handler dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [7:0] e;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    e[7:6] = 2'b00;
    return e;
  endfunction

  function automatic logic [31:0] hdr(input logic [7:0] di, input logic [15:0] wc);
    return {ecc_of({wc, di}), wc, di};
  endfunction

  function automatic ev_t pay(input logic [31:0] d, input logic [2:0] b, input logic l);
    return '{pv: 1'b1, d: d, b: b, l: l, default: 1'b0};
  endfunction

  function automatic ev_t pulse(input logic [5:0] f);
    return '{pv: 1'b0, d: 32'h0, b: 3'd0, l: 1'b0,
             fs: f[5], fe: f[4], ls: f[3], le: f[2], tr: f[1], ec: f[0]};
  endfunction

  task automatic word(input logic [31:0] d, input logic v);
    @(posedge clk);
    #1;
    bus.data_i       = d;
    bus.data_valid_i = v;
  endtask

  task automatic burst(input logic [31:0] w[$]);
    foreach (w[i]) word(w[i], 1'b1);
    repeat (2) word(32'h0, 1'b0);
  endtask

  initial begin
    ev_t act, e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.payload_valid_o || bus.frame_start_o || bus.frame_end_o || bus.line_start_o
                    || bus.line_end_o || bus.err_trunc_o || bus.err_ecc_o)) begin
        act = '{pv: bus.payload_valid_o,
                d: bus.payload_valid_o ? bus.payload_o : 32'h0,
                b: bus.payload_valid_o ? bus.payload_bytes_o : 3'd0,
                l: bus.payload_valid_o ? bus.payload_last_o : 1'b0,
                fs: bus.frame_start_o, fe: bus.frame_end_o, ls: bus.line_start_o,
                le: bus.line_end_o, tr: bus.err_trunc_o, ec: bus.err_ecc_o};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h, required no output", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL event: got %h, required %h", act, e);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] q[$];
    logic [44:0] outs;
    bus.data_i       = 32'h0;
    bus.data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs = {bus.payload_o, bus.payload_valid_o, bus.payload_last_o, bus.payload_bytes_o,
            bus.frame_start_o, bus.frame_end_o, bus.line_start_o, bus.line_end_o,
            bus.err_trunc_o, bus.err_ecc_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst_n = 1'b1;
    // Short packets: sync pulses only for VC0, generic short DT silent
    exp_q.push_back(pulse(6'b100000));
    q = {32'h0000_0000}; burst(q);
    exp_q.push_back(pulse(6'b010000));
    q = {hdr(8'h01, 16'h0000)}; burst(q);
    exp_q.push_back(pulse(6'b001000));
    q = {hdr(8'h02, 16'h0001)}; burst(q);
    exp_q.push_back(pulse(6'b000100));
    q = {hdr(8'h03, 16'h0001)}; burst(q);
    q = {hdr(8'h40, 16'h0000)}; burst(q);
    q = {hdr(8'h08, 16'h1234)}; burst(q);
    // WC=10: last word has 2 payload + 2 CRC bytes
    exp_q.push_back(pay(32'h0302_0100, 3'd4, 1'b0));
    exp_q.push_back(pay(32'h0706_0504, 3'd4, 1'b0));
    exp_q.push_back(pay(32'hC1C0_0908, 3'd2, 1'b1));
    q = {hdr(8'h2B, 16'd10), 32'h0302_0100, 32'h0706_0504, 32'hC1C0_0908}; burst(q);
    // WC=7: CRC split across words, trailing word and filler dropped
    exp_q.push_back(pay(32'h4433_2211, 3'd4, 1'b0));
    exp_q.push_back(pay(32'hC077_6655, 3'd3, 1'b1));
    q = {hdr(8'h2B, 16'd7), 32'h4433_2211, 32'hC077_6655, 32'hFFFF_FFC1, 32'h5555_5555, 32'hAAAA_AAAA};
    burst(q);
    // VC1 skipped (6 words + 1 filler), then VC0 WC=4 forwarded
    q = {hdr(8'h6B, 16'd20)};
    for (int i = 0; i < 7; i++) q.push_back(32'hA000_0000 + 32'(i));
    burst(q);
    exp_q.push_back(pay(32'hDEAD_BEEF, 3'd4, 1'b1));
    q = {hdr(8'h2B, 16'd4), 32'hDEAD_BEEF, 32'h0000_C1C0}; burst(q);
    // WC=0 long packet goes to SKIP; dropping at once is a truncation
    exp_q.push_back(pulse(6'b000010));
    q = {hdr(8'h2B, 16'd0)}; burst(q);
    // Truncated payload: no last, trunc pulse, then a clean FE
    exp_q.push_back(pay(32'h1111_1111, 3'd4, 1'b0));
    exp_q.push_back(pay(32'h2222_2222, 3'd4, 1'b0));
    exp_q.push_back(pulse(6'b000010));
    q = {hdr(8'h2B, 16'd20), 32'h1111_1111, 32'h2222_2222}; burst(q);
    exp_q.push_back(pulse(6'b010000));
    q = {hdr(8'h01, 16'h0000)}; burst(q);
    // WC=0xFFFF skip must not wrap to a tiny remainder
    exp_q.push_back(pulse(6'b000010));
    q = {hdr(8'h6B, 16'hFFFF), 32'h1, 32'h2, 32'h3}; burst(q);
    exp_q.push_back(pay(32'h3333_3333, 3'd4, 1'b0));
    exp_q.push_back(pay(32'h4444_4444, 3'd4, 1'b0));
    exp_q.push_back(pulse(6'b000010));
    q = {hdr(8'h2B, 16'hFFFF), 32'h3333_3333, 32'h4444_4444}; burst(q);
    // Reset mid-packet clears outputs immediately
    exp_q.push_back(pay(32'h5555_0000, 3'd4, 1'b0));
    word(hdr(8'h2B, 16'd20), 1'b1);
    word(32'h5555_0000, 1'b1);
    word(32'h6666_0000, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.data_valid_i = 1'b0;
    #1;
    outs = {bus.payload_o, bus.payload_valid_o, bus.payload_last_o, bus.payload_bytes_o,
            bus.frame_start_o, bus.frame_end_o, bus.line_start_o, bus.line_end_o,
            bus.err_trunc_o, bus.err_ecc_o};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midpacket_reset: got %h, required 0", outs);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(pulse(6'b100000));
    q = {32'h0000_0000}; burst(q);
`ifdef MIPI_CSI2_ECC_CHECK_EN
    // One flipped WC bit (WC 10 -> 8) is corrected back to 10
    exp_q.push_back(pay(32'h0302_0100, 3'd4, 1'b0));
    exp_q.push_back(pay(32'h0706_0504, 3'd4, 1'b0));
    exp_q.push_back(pay(32'hC1C0_0908, 3'd2, 1'b1));
    q = {hdr(8'h2B, 16'd10) ^ 32'h0000_0200, 32'h0302_0100, 32'h0706_0504, 32'hC1C0_0908}; burst(q);
    // Two flipped bits: ECC error only, burst ignored
    exp_q.push_back(pulse(6'b000001));
    q = {hdr(8'h2B, 16'd10) ^ 32'h0000_0600, 32'h0302_0100, 32'h0706_0504, 32'hC1C0_0908}; burst(q);
    exp_q.push_back(pulse(6'b000001));
    q = {hdr(8'h00, 16'h0000) ^ 32'h0000_0003}; burst(q);
`endif
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
